return_stack: RTL and testbench

//  Hardware return-address stack feeding the program counter's stack-return path.

---
 rtl/return_stack.sv | 150 +++++++++++++++
 tb/tb_return_stack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// return_stack: hardware return-address stack for the PC stack-return path.
//   CALL pushes the CALL's own PC, interrupt entry pushes the resume PC and
//   RET/RETI pop it. A pop drives the jump outputs in the same cycle, so the
//   PC loads the return address on the next edge. This block also owns the
//   global interrupt-enable flag.
//
// Parameters: W (address width = PC width), DEPTH (entries, >= 2).
// Optional feature macro: RSTACK_TAG_CHECK_EN. When it is defined, each entry
//   carries a CALL/INT tag, and a RET/RETI that does not match its tag sets err_tag.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   push_call, push_int      push requests; pc_in is the address to push
//   pop_ret, pop_reti        pop requests (both together act as RETI)
//   ret_addr                 top of stack (0 when empty)
//   skok_pc, skok_pc_stos    PC jump / stack-select, asserted when a pop is accepted
//   reti_int_en              accepted RETI (PC adds no +1)
//   int_en                   global interrupt enable
//   depth_cnt, full, empty   occupancy
//   err_ovf, err_udf, err_tag sticky error flags, cleared only by rst
module return_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_call,
  input  logic                         push_int,
  input  logic                         pop_ret,
  input  logic                         pop_reti,
  input  logic [W-1:0]                 pc_in,
  output logic [W-1:0]                 ret_addr,
  output logic                         skok_pc,
  output logic                         skok_pc_stos,
  output logic                         reti_int_en,
  output logic                         int_en,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         full,
  output logic                         empty,
  output logic                         err_ovf,
  output logic                         err_udf,
  output logic                         err_tag
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [SPW-1:0] r_depth;
  logic           r_int_en;
  logic           r_err_ovf;
  logic           r_err_udf;

  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic           w_full;
  logic           w_pop_acc;
  logic           w_push_acc;
  logic [AW-1:0]  w_top_idx;
  logic [AW-1:0]  w_wr_idx;

  // Request decode and acceptance
  assign w_push     = push_call | push_int;
  assign w_pop      = pop_ret | pop_reti;
  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == SPW'(DEPTH));
  assign w_pop_acc  = w_pop & ~w_empty;
  // An accepted pop frees the top slot, so a push in the same cycle replaces it even when full
  assign w_push_acc = w_push & (~w_full | w_pop_acc);
  assign w_top_idx  = AW'(r_depth - SPW'(1));
  assign w_wr_idx   = w_pop_acc ? w_top_idx : AW'(r_depth);

  // Pop-side outputs, combinational from registered state
  assign ret_addr     = w_empty ? '0 : r_mem[w_top_idx];
  assign skok_pc      = w_pop_acc;
  assign skok_pc_stos = w_pop_acc;
  assign reti_int_en  = w_pop_acc & pop_reti;

  assign depth_cnt = r_depth;
  assign full      = w_full;
  assign empty     = w_empty;
  assign int_en    = r_int_en;
  assign err_ovf   = r_err_ovf;
  assign err_udf   = r_err_udf;

  // Stack storage, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && w_push_acc) begin
      r_mem[w_wr_idx] <= pc_in;
    end
  end

  // Occupancy, interrupt enable and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth   <= '0;
      r_int_en  <= 1'b1;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_push_acc && !w_pop_acc) begin
        r_depth <= r_depth + SPW'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        r_depth <= r_depth - SPW'(1);
      end

      // Any interrupt entry, even a dropped one, masks interrupts and wins over RETI
      if (push_int) begin
        r_int_en <= 1'b0;
      end else if (w_pop_acc && pop_reti) begin
        r_int_en <= 1'b1;
      end

      // Simultaneous CALL and INT: only the INT is stored, the CALL counts as lost
      if ((w_push && !w_push_acc) || (push_call && push_int)) begin
        r_err_ovf <= 1'b1;
      end
      if (w_pop && w_empty) begin
        r_err_udf <= 1'b1;
      end
    end
  end

`ifdef RSTACK_TAG_CHECK_EN
  // Per-entry origin tag: 0 = CALL, 1 = INT
  logic r_tag [DEPTH];
  logic r_err_tag;

  always_ff @(posedge clk) begin
    if (!rst && w_push_acc) begin
      r_tag[w_wr_idx] <= push_int;
    end
  end

  // RET must pop a CALL entry and RETI an INT entry; the pop itself is not blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_tag <= 1'b0;
    end else if (w_pop_acc && (r_tag[w_top_idx] != pop_reti)) begin
      r_err_tag <= 1'b1;
    end
  end

  assign err_tag = r_err_tag;
`else
  assign err_tag = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack. It keeps a queue-based scoreboard of the
// stack contents: pushes are queued when driven, and pops take the expected
// return address from the back of the queue.
module tb_return_stack;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SPW   = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           push_call = 1'b0;
  logic           push_int = 1'b0;
  logic           pop_ret = 1'b0;
  logic           pop_reti = 1'b0;
  logic [W-1:0]   pc_in = '0;
  logic [W-1:0]   ret_addr;
  logic           skok_pc;
  logic           skok_pc_stos;
  logic           reti_int_en;
  logic           int_en;
  logic [SPW-1:0] depth_cnt;
  logic           full;
  logic           empty;
  logic           err_ovf;
  logic           err_udf;
  logic           err_tag;

  return_stack #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_call    (push_call),
    .push_int     (push_int),
    .pop_ret      (pop_ret),
    .pop_reti     (pop_reti),
    .pc_in        (pc_in),
    .ret_addr     (ret_addr),
    .skok_pc      (skok_pc),
    .skok_pc_stos (skok_pc_stos),
    .reti_int_en  (reti_int_en),
    .int_en       (int_en),
    .depth_cnt    (depth_cnt),
    .full         (full),
    .empty        (empty),
    .err_ovf      (err_ovf),
    .err_udf      (err_udf),
    .err_tag      (err_tag)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Scoreboard state
  logic [W-1:0] sb_addr [$];
  logic         sb_tag  [$];
  logic         m_int_en  = 1'b1;
  logic         m_err_ovf = 1'b0;
  logic         m_err_udf = 1'b0;
  logic         m_err_tag = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".depth"},   32'(depth_cnt), 32'(sb_addr.size()));
    chk({tag, ".empty"},   32'(empty),     32'(sb_addr.size() == 0));
    chk({tag, ".full"},    32'(full),      32'(sb_addr.size() == DEPTH));
    chk({tag, ".int_en"},  32'(int_en),    32'(m_int_en));
    chk({tag, ".err_ovf"}, 32'(err_ovf),   32'(m_err_ovf));
    chk({tag, ".err_udf"}, 32'(err_udf),   32'(m_err_udf));
`ifdef RSTACK_TAG_CHECK_EN
    chk({tag, ".err_tag"}, 32'(err_tag),   32'(m_err_tag));
`else
    chk({tag, ".err_tag"}, 32'(err_tag),   32'(0));
`endif
  endtask

  // One clock of stimulus. Combinational pop outputs are checked before the edge,
  // registered state #1 after it.
  task automatic cyc(input logic pc, input logic pi, input logic pr, input logic pri,
                     input logic [W-1:0] pcv, input string tag);
    logic         was_empty;
    logic         was_full;
    logic         acc;
    logic [W-1:0] exp_ret;
    push_call = pc; push_int = pi; pop_ret = pr; pop_reti = pri; pc_in = pcv;
    #1;
    was_empty = (sb_addr.size() == 0);
    was_full  = (sb_addr.size() == DEPTH);
    acc       = (pr | pri) & ~was_empty;
    exp_ret   = was_empty ? '0 : sb_addr[$];
    chk({tag, ".ret_addr"},    32'(ret_addr),     32'(exp_ret));
    chk({tag, ".skok_pc"},     32'(skok_pc),      32'(acc));
    chk({tag, ".skok_stos"},   32'(skok_pc_stos), 32'(acc));
    chk({tag, ".reti_int_en"}, 32'(reti_int_en),  32'(acc & pri));
    if (acc) begin
      if (sb_tag[$] != pri) m_err_tag = 1'b1;
      void'(sb_addr.pop_back());
      void'(sb_tag.pop_back());
    end
    if ((pc | pi) && (!was_full || acc)) begin
      sb_addr.push_back(pcv);
      sb_tag.push_back(pi);
    end
    if (((pc | pi) && was_full && !acc) || (pc && pi)) m_err_ovf = 1'b1;
    if ((pr | pri) && was_empty) m_err_udf = 1'b1;
    if (pi) m_int_en = 1'b0;
    else if (acc && pri) m_int_en = 1'b1;
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  // Reset with pushes/pops asserted to show reset dominates
  task automatic do_reset(input string tag);
    rst = 1'b1; push_call = 1'b1; push_int = 1'b1; pop_ret = 1'b1; pop_reti = 1'b1; pc_in = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; push_call = 1'b0; push_int = 1'b0; pop_ret = 1'b0; pop_reti = 1'b0;
    sb_addr.delete();
    sb_tag.delete();
    m_int_en = 1'b1; m_err_ovf = 1'b0; m_err_udf = 1'b0; m_err_tag = 1'b0;
    chk_regs(tag);
    chk({tag, ".ret_addr"}, 32'(ret_addr), 32'(0));
  endtask

  initial begin
    @(posedge clk);
    do_reset("rst0");

    // CALL then RET
    cyc(1, 0, 0, 0, 8'h10, "call10");
    chk("call10.top", 32'(ret_addr), 32'h10);
    cyc(0, 0, 1, 0, 8'h00, "ret10");
    chk("ret10.empty", 32'(empty), 32'(1));

    // Interrupt entry then RETI
    cyc(0, 1, 0, 0, 8'h22, "int22");
    chk("int22.int_en", 32'(int_en), 32'(0));
    cyc(0, 0, 0, 1, 8'h00, "reti22");
    chk("reti22.int_en", 32'(int_en), 32'(1));

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, W'(i), "fill");
    chk("fill.full", 32'(full), 32'(1));
    cyc(1, 0, 0, 0, 8'h09, "ovf");
    chk("ovf.err_ovf", 32'(err_ovf), 32'(1));
    for (int i = 8; i >= 1; i--) begin
      chk("drain.top", 32'(ret_addr), 32'(i));
      cyc(0, 0, 1, 0, 8'h00, "drain");
    end

    // Underflow
    do_reset("rst1");
    cyc(0, 0, 1, 0, 8'h00, "udf");
    chk("udf.err_udf", 32'(err_udf), 32'(1));

    // Push with accepted pop replaces the top
    do_reset("rst2");
    cyc(1, 0, 0, 0, 8'h30, "push30");
    cyc(1, 0, 1, 0, 8'h40, "swap40");
    chk("swap40.top", 32'(ret_addr), 32'h40);
    cyc(0, 0, 1, 0, 8'h00, "pop40");

    // Simultaneous CALL+INT, then simultaneous RET+RETI
    cyc(1, 1, 0, 0, 8'h61, "callint");
    cyc(0, 0, 1, 1, 8'h00, "retreti");

    // Push with pop while empty
    cyc(1, 0, 1, 0, 8'h55, "pushpop_empty");

    // Rejected INT still masks; INT beats RETI for int_en
    do_reset("rst3");
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, W'(8'hA0 + i), "fill_int");
    cyc(0, 0, 0, 1, 8'h00, "reti_full");
    cyc(1, 0, 0, 0, 8'h77, "refill");
    cyc(0, 1, 0, 0, 8'hB0, "int_on_full");
    cyc(0, 1, 0, 1, 8'hB1, "int_reti");
    cyc(1, 0, 1, 0, 8'hC0, "swap_full");

`ifdef RSTACK_TAG_CHECK_EN
    do_reset("rst_tag");
    cyc(1, 0, 0, 0, 8'h50, "tag_call50");
    cyc(0, 0, 0, 1, 8'h00, "tag_reti50");
    chk("tag.err_tag", 32'(err_tag), 32'(1));
    cyc(1, 0, 0, 0, 8'h51, "tag_mid1");
    cyc(1, 0, 0, 0, 8'h52, "tag_mid2");
`endif

    // Mid-stack reset
    do_reset("rst_mid");

    // Random traffic against the scoreboard
    for (int n = 0; n < 300; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      cyc(r[0] & ($urandom_range(0, 2) != 0), r[1] & ($urandom_range(0, 3) == 0),
          r[2], r[3] & r[2], W'($urandom), "rand");
      if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
